// File: rtl/sid_pkg.sv
// Shared constants, sample type and offset-binary conversion for the SID audio path.
// Latency: none (package only).
// Backpressure: none (package only).
package sid_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned SLOT_BITS  = 16;

    typedef logic [SLOT_BITS-1:0] sample_t;

    localparam sample_t MIDSCALE = 16'h8000;

    // Unsigned offset-binary to two's complement: flip the MSB.
    function automatic sample_t u2s(input sample_t x);
        return x ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/sid_bclk_div.sv
// I2S bit-clock generator: toggles bclk every BCLK_DIV clk cycles, flags the 1->0 toggle.
// Latency: bclk is registered; fall_evt is high in the cycle whose edge drives bclk low.
// Backpressure: none, free-running from reset.
module sid_bclk_div #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic clk,
    input  logic n_reset,
    output logic bclk,
    output logic fall_evt
);

    localparam logic [7:0] TERM = 8'(BCLK_DIV - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;
    logic       bclk_q;
    logic       bclk_d;
    logic       term;

    assign term     = (div_cnt_q == TERM);
    // Fall event coincides with the edge on which the registered bclk drops.
    assign fall_evt = term & bclk_q;
    assign bclk     = bclk_q;

    // Next-state: wrap the divider at terminal count and toggle bclk there.
    always_comb begin
        div_cnt_d = div_cnt_q + 8'd1;
        bclk_d    = bclk_q;
        if (term) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    // Divider state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID filter output; latest sample wins at each frame load.
// Latency: strobe to MSB on pin at most 64*BCLK_DIV+1 clk; frame period 64*BCLK_DIV clk.
// Backpressure: none; unsent samples are replaced and flagged on sample_overwrite.
// Optional: define SID_I2S_STEREO_EN to add audio_in_r for an independent right slot.
module sid_i2s_tx
    import sid_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [15:0]   audio_in,
`ifdef SID_I2S_STEREO_EN
    input  logic [15:0]   audio_in_r,
`endif
    input  logic          sample_valid,
    output logic          i2s_bclk,
    output logic          i2s_lrclk,
    output logic          i2s_sdata,
    output logic          frame_start,
    output logic          sample_overwrite
);

    localparam int unsigned CW = $clog2(FRAME_BITS);

    logic                  fall_evt;

    sample_t               hold_q, hold_d;
    logic                  fresh_q, fresh_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  lrclk_q, lrclk_d;
    logic                  frame_start_q, frame_start_d;
    logic                  overwrite_q, overwrite_d;
    logic                  load;
    sample_t               cur_l, cur_r;

    sid_bclk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_div (
        .clk      (clk),
        .n_reset  (n_reset),
        .bclk     (i2s_bclk),
        .fall_evt (fall_evt)
    );

`ifdef SID_I2S_STEREO_EN
    sample_t hold_r_q, hold_r_d;

    // Right-slot hold register, captured on the same strobe as the left.
    always_comb begin
        hold_r_d = hold_r_q;
        if (sample_valid) hold_r_d = audio_in_r;
        cur_r = sample_valid ? audio_in_r : hold_r_q;
    end

    // Right-slot hold state.
    always_ff @(posedge clk) begin
        if (!n_reset) hold_r_q <= MIDSCALE;
        else          hold_r_q <= hold_r_d;
    end
`else
    // Without a separate right input both slots carry the same sample.
    always_comb begin
        cur_r = cur_l;
    end
`endif

    // Capture, frame load/shift, word select and status pulses.
    always_comb begin
        hold_d        = hold_q;
        fresh_d       = fresh_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        lrclk_d       = lrclk_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        // A strobe on the load cycle bypasses the hold register.
        cur_l         = sample_valid ? audio_in : hold_q;

        if (sample_valid) begin
            hold_d  = audio_in;
            fresh_d = 1'b1;
        end

        if (fall_evt) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // WS leads each slot's MSB by one bit clock.
            lrclk_d   = (bit_cnt_d >= CW'(SLOT_BITS - 1)) &&
                        (bit_cnt_d <= CW'(FRAME_BITS - 2));
            if (bit_cnt_d == '0) begin
                load          = 1'b1;
                shift_d       = {u2s(cur_l), u2s(cur_r)};
                fresh_d       = 1'b0;
                frame_start_d = 1'b1;
            end else begin
                shift_d = shift_q << 1;
            end
        end

        overwrite_d = sample_valid & fresh_q & ~load;
    end

    // Main state with synchronous active-low reset; any reset aborts the frame.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            hold_q        <= MIDSCALE;
            fresh_q       <= 1'b0;
            bit_cnt_q     <= CW'(FRAME_BITS - 1);
            shift_q       <= '0;
            lrclk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            overwrite_q   <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            fresh_q       <= fresh_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            lrclk_q       <= lrclk_d;
            frame_start_q <= frame_start_d;
            overwrite_q   <= overwrite_d;
        end
    end

    assign i2s_sdata        = shift_q[FRAME_BITS-1];
    assign i2s_lrclk        = lrclk_q;
    assign frame_start      = frame_start_q;
    assign sample_overwrite = overwrite_q;

endmodule
